// File: rtl/branch_cmp_pkg.sv
// Shared op codes, FSM encoding and op-decoding helpers for the
// branch-condition resolver.
package branch_cmp_pkg;

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_NE  = 3'b001,
        OP_LTZ = 3'b010,
        OP_GEZ = 3'b011,
        OP_LEZ = 3'b100,
        OP_GTZ = 3'b101,
        OP_LTU = 3'b110,
        OP_LT  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Zero-compare ops ignore rt and compare rs against 0.
    function automatic logic op_is_zero_cmp(op_e op);
        return (op == OP_LTZ) || (op == OP_GEZ) || (op == OP_LEZ) || (op == OP_GTZ);
    endfunction

    function automatic logic op_is_signed(op_e op);
        return op != OP_LTU;
    endfunction

    function automatic logic op_taken(op_e op, logic eq, logic lt);
        logic t;
        case (op)
            OP_EQ:   t = eq;
            OP_NE:   t = !eq;
            OP_LTZ:  t = lt;
            OP_GEZ:  t = !lt;
            OP_LEZ:  t = lt | eq;
            OP_GTZ:  t = !lt & !eq;
            default: t = lt;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_cmp_unit_if.sv
// Request/result handshake bundle between the branch/hazard unit (master)
// and the compare unit (slave).
interface branch_cmp_unit_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic             out_eq;
    logic             out_lt;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_taken, out_eq, out_lt
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_taken, out_eq, out_lt
    );

endinterface

// File: rtl/slice_cmp.sv
// Combinational compare of one operand slice; the top slice of a signed
// operand is compared as two's complement.
module slice_cmp #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             is_signed_msb,
    output logic             ne,
    output logic             lt
);

    always_comb begin
        ne = (x != y);
        if (is_signed_msb) lt = ($signed(x) < $signed(y));
        else               lt = (x < y);
    end

endmodule

// File: rtl/branch_cmp_unit.sv
// Multi-cycle MIPS branch-condition resolver: compares rs/rt one slice per
// cycle from the MSB slice down, with optional exit on the first difference.
module branch_cmp_unit
    import branch_cmp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SLICE      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    branch_cmp_unit_if.slave   bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NSLICE - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_cfg
        $error("branch_cmp_unit: WIDTH must be a multiple of SLICE");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    op_e              op_q, op_d;
    logic             sgn_q, sgn_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             dec_q, dec_d;

    logic [SLICE-1:0] slice_a, slice_b;
    logic             slice_ne, slice_lt, slice_signed;
    logic             first_diff;
    op_e              op_in;

    assign slice_a      = a_q[int'(idx_q)*SLICE +: SLICE];
    assign slice_b      = b_q[int'(idx_q)*SLICE +: SLICE];
    assign slice_signed = sgn_q && (idx_q == IDX_MSB);
    assign first_diff   = slice_ne && !dec_q;
    assign op_in        = op_e'(bus.in_op);

    slice_cmp #(.SLICE(SLICE)) u_slice_cmp (
        .x             (slice_a),
        .y             (slice_b),
        .is_signed_msb (slice_signed),
        .ne            (slice_ne),
        .lt            (slice_lt)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        dec_d   = dec_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = op_is_zero_cmp(op_in) ? '0 : bus.in_b;
                    op_d    = op_in;
                    sgn_d   = op_is_signed(op_in);
                    idx_d   = IDX_MSB;
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    dec_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Only the most significant differing slice sets the result.
                if (first_diff) begin
                    dec_d = 1'b1;
                    eq_d  = 1'b0;
                    lt_d  = slice_lt;
                end
                if ((idx_q == '0) || ((EARLY_EXIT != 0) && first_diff)) state_d = ST_DONE;
                else idx_d = idx_q - IDX_W'(1);
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_EQ;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            dec_q   <= dec_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_eq    = bus.out_valid & eq_q;
    assign bus.out_lt    = bus.out_valid & lt_q;
    assign bus.out_taken = bus.out_valid & op_taken(op_q, eq_q, lt_q);

endmodule
